// File: rtl/regfile_scb_pkg.sv
// regfile_scb_pkg: default register file geometry and address type
package regfile_scb_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AW = $clog2(DEF_DEPTH);
  typedef logic [DEF_AW-1:0] rf_addr_t;
endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one read port -- array mux, write bypass, zero register and reset gating
// Ports: regs/busy (register array and busy vector), we/waddr/wdata and rsv/raddr
// (already zero-filtered write and reserve), addr (read address), data/rbusy (read result).
module regfile_rdport import regfile_scb_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic             reset,
  input  logic [WIDTH-1:0] regs [DEPTH],
  input  logic [DEPTH-1:0] busy,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rsv,
  input  logic [AW-1:0]    raddr,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data,
  output logic             rbusy
);
  logic hit, kill;
  assign hit = BYPASS != 0 && we && waddr == addr;
  // reset must also mask the bypass path, which does not go through the flops
  assign kill = !reset || (ZERO_REG != 0 && addr == '0);
  assign data = kill ? '0 : hit ? wdata : regs[addr];
  // a same-cycle reserve of the bypassed register wins over the write clearing it
  assign rbusy = kill ? 1'b0 : hit ? (rsv && raddr == addr) : busy[addr];
endmodule

// File: rtl/regfile_scb.sv
// regfile_scb: register file with per-register busy scoreboard and optional write bypass
// Ports: clk, reset (async active-low); RegWrite/WriteReg/WriteData write port;
// Reserve/ReserveReg marks a register busy; ReadReg1/2 -> ReadData1/2, ReadBusy1/2;
// BusyCount is the number of busy registers.
module regfile_scb import regfile_scb_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             Reserve,
  input  logic [AW-1:0]    ReserveReg,
  input  logic [AW-1:0]    ReadReg1,
  input  logic [AW-1:0]    ReadReg2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  output logic             ReadBusy1,
  output logic             ReadBusy2,
  output logic [AW:0]      BusyCount
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy, busy_nxt;
  logic we, rsv;
  assign we = RegWrite && !(ZERO_REG != 0 && WriteReg == '0);
  assign rsv = Reserve && !(ZERO_REG != 0 && ReserveReg == '0);
  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[WriteReg] = 1'b0;
    if (rsv) busy_nxt[ReserveReg] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (we) regs[WriteReg] <= WriteData;
      busy <= busy_nxt;
    end
  assign BusyCount = (AW+1)'($countones(busy));
  regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd1 (
    .reset(reset), .regs(regs), .busy(busy), .we(we), .waddr(WriteReg), .wdata(WriteData),
    .rsv(rsv), .raddr(ReserveReg), .addr(ReadReg1), .data(ReadData1), .rbusy(ReadBusy1)
  );
  regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_rd2 (
    .reset(reset), .regs(regs), .busy(busy), .we(we), .waddr(WriteReg), .wdata(WriteData),
    .rsv(rsv), .raddr(ReserveReg), .addr(ReadReg2), .data(ReadData2), .rbusy(ReadBusy2)
  );
endmodule
